pte_ad_writeback: RTL and testbench

- Write-side counterpart of the PTE decode path: takes a leaf Sv39 PTE found by the page-table walker and re-encodes it with the Accessed (A) and, for stores, Dirty (D) bits set.
- Writes the updated PTE back to memory through a valid/ready memory port, then returns the final PTE and a fault flag to the walker.
- Sits between the PTW and the D-side memory arbiter.

---
 rtl/pte_ad_writeback_pkg.sv | 48 ++++
 rtl/pte_ad_writeback_encode.sv | 21 ++
 rtl/pte_ad_writeback.sv | 154 +++++++++++++++
 tb/tb_pte_ad_writeback.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pte_ad_writeback_pkg.sv
// pte_ad_writeback_pkg: Sv39 PTE layout, bit indices, FSM state codes and fault/A-D helpers
// shared by the PTE A/D writeback block.
package pte_ad_writeback_pkg;

  localparam int PTE_V = 0;
  localparam int PTE_R = 1;
  localparam int PTE_W = 2;
  localparam int PTE_X = 3;
  localparam int PTE_U = 4;
  localparam int PTE_G = 5;
  localparam int PTE_A = 6;
  localparam int PTE_D = 7;

  typedef struct packed {
    logic [9:0]  rsvd;
    logic [43:0] ppn;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } pte_t;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_WACK  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;
  localparam logic [2:0] S_RD    = 3'd5;
  localparam logic [2:0] S_RWAIT = 3'd6;

  function automatic logic pte_fault(input pte_t p, input logic store);
    return !p.v || (!p.r && p.w) || (!p.r && !p.x) || (store && !p.w);
  endfunction

  function automatic pte_t pte_set_ad(input pte_t p, input logic store);
    pte_t n;
    n   = p;
    n.a = 1'b1;
    n.d = p.d | store;
    return n;
  endfunction

endpackage

// File: rtl/pte_ad_writeback_encode.sv
// pte_encode: packs a pte_t into the raw 64-bit Sv39 PTE image, the inverse of the decode path.
module pte_encode
  import pte_ad_writeback_pkg::*;
(
  input  pte_t        pte,
  output logic [63:0] raw
);

  always_comb begin
    raw        = {pte.rsvd, pte.ppn, pte.rsw, 8'h00};
    raw[PTE_V] = pte.v;
    raw[PTE_R] = pte.r;
    raw[PTE_W] = pte.w;
    raw[PTE_X] = pte.x;
    raw[PTE_U] = pte.u;
    raw[PTE_G] = pte.g;
    raw[PTE_A] = pte.a;
    raw[PTE_D] = pte.d;
  end

endmodule

// File: rtl/pte_ad_writeback.sv
// pte_ad_writeback: sets A (and D on stores) in a leaf Sv39 PTE and writes byte 0 back to memory.
// Optional PTE_AD_ATOMIC_EN re-reads the PTE from memory before writing to close software-edit races.
module pte_ad_writeback
  import pte_ad_writeback_pkg::*;
#(
  parameter int PADDR_WIDTH = 56,
  parameter int MEM_LAT_MAX = 255
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [PADDR_WIDTH-1:0] req_addr,
  input  logic [63:0]            req_pte,
  input  logic                   req_store,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic                   mem_we,
  output logic [PADDR_WIDTH-1:0] mem_addr,
  output logic [63:0]            mem_wdata,
  output logic [7:0]             mem_wmask,
  input  logic                   mem_resp_valid,
  input  logic [63:0]            mem_rdata,
  output logic                   done_valid,
  input  logic                   done_ready,
  output logic [63:0]            done_pte,
  output logic                   done_fault
);

  localparam int CW = $clog2(MEM_LAT_MAX + 1);

  logic [2:0]             state;
  logic [PADDR_WIDTH-1:0] addr_q;
  pte_t                   pte_q;
  logic                   store_q;
  logic [CW-1:0]          cnt;
  logic [63:0]            done_pte_q;
  logic                   done_fault_q;
  logic [63:0]            new_raw;
  logic                   fault;
  logic                   skip;
  logic                   timeout;

  pte_encode u_encode (
    .pte (pte_set_ad(pte_q, store_q)),
    .raw (new_raw)
  );

  assign fault   = pte_fault(pte_q, store_q);
  assign skip    = pte_q.a && (!store_q || pte_q.d);
  assign timeout = cnt == CW'(MEM_LAT_MAX);

`ifdef PTE_AD_ATOMIC_EN
  logic verified_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;
`endif

  // All memory-side outputs decode from registered state so an async reset drops them at once.
  assign req_ready     = state == S_IDLE;
  assign mem_req_valid = state == S_WRITE || state == S_RD;
  assign mem_we        = state == S_WRITE;
  assign mem_addr      = mem_req_valid ? addr_q : '0;
  assign mem_wdata     = mem_we ? new_raw : '0;
  assign mem_wmask     = mem_we ? 8'h01 : mem_req_valid ? 8'hFF : 8'h00;
  assign done_valid    = state == S_RESP;
  assign done_pte      = done_pte_q;
  assign done_fault    = done_fault_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_IDLE;
      addr_q       <= '0;
      pte_q        <= '0;
      store_q      <= 1'b0;
      cnt          <= '0;
      done_pte_q   <= '0;
      done_fault_q <= 1'b0;
`ifdef PTE_AD_ATOMIC_EN
      verified_q   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          addr_q  <= req_addr;
          pte_q   <= pte_t'(req_pte);
          store_q <= req_store;
          state   <= S_CHECK;
`ifdef PTE_AD_ATOMIC_EN
          verified_q <= 1'b0;
`endif
        end
        S_CHECK: begin
          cnt <= '0;
          if (fault || skip) begin
            done_pte_q   <= pte_q;
            done_fault_q <= fault;
            state        <= S_RESP;
          end
`ifdef PTE_AD_ATOMIC_EN
          else state <= verified_q ? S_WRITE : S_RD;
`else
          else state <= S_WRITE;
`endif
        end
        S_WRITE: if (mem_req_ready) begin
          cnt   <= '0;
          state <= S_WACK;
        end else if (timeout) begin
          done_pte_q   <= pte_q;
          done_fault_q <= 1'b1;
          state        <= S_RESP;
        end else cnt <= cnt + 1'b1;
        S_WACK: if (mem_resp_valid) begin
          done_pte_q   <= new_raw;
          done_fault_q <= 1'b0;
          state        <= S_RESP;
        end else if (timeout) begin
          done_pte_q   <= pte_q;
          done_fault_q <= 1'b1;
          state        <= S_RESP;
        end else cnt <= cnt + 1'b1;
`ifdef PTE_AD_ATOMIC_EN
        S_RD: if (mem_req_ready) begin
          cnt   <= '0;
          state <= S_RWAIT;
        end else if (timeout) begin
          done_pte_q   <= pte_q;
          done_fault_q <= 1'b1;
          state        <= S_RESP;
        end else cnt <= cnt + 1'b1;
        // The fresh copy goes back through CHECK so fault and already-set rules apply to it.
        S_RWAIT: if (mem_resp_valid) begin
          pte_q      <= pte_t'(mem_rdata);
          verified_q <= 1'b1;
          state      <= S_CHECK;
        end else if (timeout) begin
          done_pte_q   <= pte_q;
          done_fault_q <= 1'b1;
          state        <= S_RESP;
        end else cnt <= cnt + 1'b1;
`endif
        S_RESP: if (done_ready) begin
          done_pte_q   <= '0;
          done_fault_q <= 1'b0;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pte_ad_writeback.sv
// tb_pte_ad_writeback: directed vectors with a response scoreboard and a memory model that
// checks every write against an expected-write queue.
module tb_pte_ad_writeback;

  logic        clk;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic [55:0] req_addr;
  logic [63:0] req_pte;
  logic        req_store;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [55:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_resp_valid_m;
  logic        stray;
  logic [63:0] mem_rdata;
  logic        done_valid;
  logic        done_ready;
  logic [63:0] done_pte;
  logic        done_fault;

  typedef struct {logic [63:0] pte; logic fault;} rs_t;
  typedef struct {logic [63:0] addr; logic [63:0] data; logic [7:0] mask;} wr_t;
  rs_t sb[$];
  wr_t wq[$];

  int total = 0;
  int bad = 0;
  int nreq = 0;
  int nwr = 0;
  int ready_delay = 0;
  int ack_delay = 1;
  logic never_ack = 0;
  logic [63:0] rd_data = '0;

  pte_ad_writeback #(.PADDR_WIDTH(56), .MEM_LAT_MAX(16)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_pte(req_pte), .req_store(req_store),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid_m | stray), .mem_rdata(mem_rdata),
    .done_valid(done_valid), .done_ready(done_ready), .done_pte(done_pte), .done_fault(done_fault)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", n, a, e);
    end
  endtask

  // Response monitor: pops the scoreboard on each done handshake.
  initial forever begin
    @(negedge clk);
    if (rstn && done_valid && done_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected done: got pte 0x%0h fault %0b want none", done_pte, done_fault);
      end else begin
        rs_t r;
        r = sb.pop_front();
        chk("done_pte", done_pte, r.pte);
        chk("done_fault", done_fault, r.fault);
      end
    end
  end

  // Memory model: optional ready delay with stability check, then an ack unless never_ack.
  initial begin
    logic [63:0] a0, d0;
    logic we0;
    wr_t w;
    mem_req_ready = 0;
    mem_resp_valid_m = 0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rstn && mem_req_valid) begin
        a0 = mem_addr;
        d0 = mem_wdata;
        we0 = mem_we;
        for (int i = 0; i < ready_delay; i++) begin
          @(negedge clk);
          chk("hold valid", mem_req_valid, 1);
          chk("hold addr", mem_addr, a0);
          chk("hold wdata", mem_wdata, d0);
        end
        mem_req_ready = 1;
        nreq++;
        if (we0) begin
          nwr++;
          if (wq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected write: got addr 0x%0h data 0x%0h want none", mem_addr, mem_wdata);
          end else begin
            w = wq.pop_front();
            chk("wr addr", mem_addr, w.addr);
            chk("wr data", mem_wdata, w.data);
            chk("wr mask", mem_wmask, w.mask);
          end
        end else chk("rd mask", mem_wmask, 8'hFF);
        @(negedge clk);
        mem_req_ready = 0;
        if (!never_ack) begin
          repeat (ack_delay) @(negedge clk);
          mem_rdata = we0 ? 64'h0 : rd_data;
          mem_resp_valid_m = 1;
          @(negedge clk);
          mem_resp_valid_m = 0;
        end
      end
    end
  end

  task automatic issue(input logic [55:0] a, input logic [63:0] p, input logic s);
    req_addr = a;
    req_pte = p;
    req_store = s;
    req_valid = 1;
    for (int i = 0; i < 100; i++) begin
      if (req_ready) begin
        @(posedge clk);
        #1 req_valid = 0;
        return;
      end
      @(posedge clk);
      #1;
    end
    req_valid = 0;
    total++;
    bad++;
    $display("FAIL accept timeout: got req_ready 0 want 1");
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0 && req_ready) return;
      @(posedge clk);
      #1;
    end
    total++;
    bad++;
    $display("FAIL done timeout: got %0d pending want 0", sb.size());
    sb.delete();
  endtask

  task automatic run(input string n, input logic [55:0] a, input logic [63:0] p, input logic s,
                     input logic [63:0] ep, input logic ef, input logic wr);
    int n0;
    n0 = nreq;
    rd_data = p;
    sb.push_back('{ep, ef});
    if (wr) wq.push_back('{{8'h0, a}, ep, 8'h01});
    issue(a, p, s);
    wait_done();
    chk({n, " pending writes"}, wq.size(), 0);
    if (!wr) chk({n, " traffic"}, nreq, n0);
  endtask

  initial begin
    int n0;
    rstn = 0;
    req_valid = 0;
    req_addr = '0;
    req_pte = '0;
    req_store = 0;
    done_ready = 1;
    stray = 0;
    #1;
    chk("rst req_ready", req_ready, 1);
    chk("rst mem_req_valid", mem_req_valid, 0);
    chk("rst mem_wmask", mem_wmask, 0);
    chk("rst done_valid", done_valid, 0);
    chk("rst done_pte", done_pte, 0);
    chk("rst done_fault", done_fault, 0);
    #20;
    @(posedge clk);
    #1 rstn = 1;
    @(posedge clk);
    #1;

    // Already-set A/D: minimum latency, no memory traffic.
    n0 = nreq;
    rd_data = 64'h2000_04CF;
    sb.push_back('{64'h2000_04CF, 1'b0});
    issue(56'h8000_1000, 64'h2000_04CF, 0);
    chk("lat cycle1 done_valid", done_valid, 0);
    @(posedge clk);
    #1 chk("lat cycle2 done_valid", done_valid, 1);
    wait_done();
    chk("ad set traffic", nreq, n0);

    ready_delay = 3;
    run("store ad", 56'h8000_1008, 64'h2000_040F, 1, 64'h2000_04CF, 0, 1);
    ready_delay = 0;
    run("load a only", 56'h8000_2000, 64'hFFC0_0000_1234_5403, 0, 64'hFFC0_0000_1234_5443, 0, 1);
    run("store d only", 56'h8000_2010, 64'h2000_0447, 1, 64'h2000_04C7, 0, 1);
    run("store w0", 56'h8000_3000, 64'h2000_040B, 1, 64'h2000_040B, 1, 0);
    run("reserved rw", 56'h8000_3008, 64'h2000_0405, 0, 64'h2000_0405, 1, 0);
    run("non-leaf", 56'h8000_3010, 64'h2000_0401, 0, 64'h2000_0401, 1, 0);
    run("invalid", 56'h8000_3018, 64'h2000_04CE, 0, 64'h2000_04CE, 1, 0);

    // Back-pressure on the result.
    done_ready = 0;
    sb.push_back('{64'h2000_04CF, 1'b0});
    issue(56'h8000_4000, 64'h2000_04CF, 0);
    for (int i = 0; i < 10 && !done_valid; i++) begin
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 5; i++) begin
      chk("hold done_valid", done_valid, 1);
      chk("hold done_pte", done_pte, 64'h2000_04CF);
      chk("hold req_ready", req_ready, 0);
      @(posedge clk);
      #1;
    end
    done_ready = 1;
    wait_done();

    // No acknowledge: timeout fault, then a stray ack must be ignored.
    never_ack = 1;
    sb.push_back('{64'h2000_0407, 1'b1});
`ifndef PTE_AD_ATOMIC_EN
    wq.push_back('{64'h8000_5000, 64'h2000_04C7, 8'h01});
`endif
    issue(56'h8000_5000, 64'h2000_0407, 1);
    wait_done();
    chk("timeout pending writes", wq.size(), 0);
    never_ack = 0;
    stray = 1;
    @(posedge clk);
    #1 stray = 0;
    @(posedge clk);
    #1;
    chk("stray req_ready", req_ready, 1);
    chk("stray done_valid", done_valid, 0);
    chk("stray mem_req_valid", mem_req_valid, 0);

`ifdef PTE_AD_ATOMIC_EN
    n0 = nwr;
    rd_data = 64'h2000_040E;
    sb.push_back('{64'h2000_040E, 1'b1});
    issue(56'h8000_6000, 64'h2000_040F, 1);
    wait_done();
    chk("atomic v0 writes", nwr, n0);
    rd_data = 64'h2000_04CF;
    sb.push_back('{64'h2000_04CF, 1'b0});
    issue(56'h8000_6008, 64'h2000_040F, 1);
    wait_done();
    chk("atomic set writes", nwr, n0);
`endif

    // Reset while waiting for the write acknowledge.
    ack_delay = 10;
    rd_data = 64'h2000_0403;
    wq.push_back('{64'h8000_7000, 64'h2000_0443, 8'h01});
    issue(56'h8000_7000, 64'h2000_0403, 0);
    n0 = 0;
    for (int i = 0; i < 100 && n0 == 0; i++) begin
      if (mem_req_valid && mem_we) n0 = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    for (int i = 0; i < 100 && mem_req_valid; i++) begin
      @(posedge clk);
      #1;
    end
    chk("wack reached", {31'h0, n0[0], 31'h0, mem_req_valid}, 64'h1_0000_0000);
    #2 rstn = 0;
    #1;
    chk("abort mem_req_valid", mem_req_valid, 0);
    chk("abort mem_addr", mem_addr, 0);
    chk("abort mem_wdata", mem_wdata, 0);
    chk("abort mem_wmask", mem_wmask, 0);
    chk("abort done_valid", done_valid, 0);
    chk("abort req_ready", req_ready, 1);
    @(posedge clk);
    #1 rstn = 1;
    repeat (15) @(posedge clk);
    #1;
    chk("abort no done", done_valid, 0);
    chk("abort pending writes", wq.size(), 0);
    ack_delay = 1;
    run("after abort", 56'h8000_7008, 64'h2000_0403, 0, 64'h2000_0443, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
